// File: rtl/slr_ins_frame_tx.sv
// ---------------------------------------------------------------------------
// slr_ins_frame_tx
//
// Buffers instruction records from the SLR receive path and sends each one
// out as a framed byte stream with a valid/ready handshake. The stream feeds
// the host-upload UART/packet mux.
//
// Record layout (rxins_data): [575:512] 8-byte time, [511:0] 64 data bytes.
// Frame: HEAD_HI HEAD_LO TYPE LEN  T0..T7  D0..D(N-1)  CHK
//        LEN = 8+N. CHK is the mod-256 sum of TYPE, LEN, time and data bytes.
//
// Optional feature (macro SLR_INS_FRAME_CRC16_EN):
//   CHK is replaced by CRC-16/CCITT (poly 0x1021, init 0xFFFF, no reflection,
//   no final XOR) over the same bytes, sent high byte first.
//
// Ports:
//   clk_sys, rst_n        system clock, async active-low reset
//   cfg_ins_length [7:0]  data bytes per frame (0 or >64 means 64)
//   rxins_data [575:0]    record, qualified by rxins_data_valid (1 cycle)
//   tx_data [7:0]         frame byte, qualified by tx_data_valid
//   tx_data_ready         sink accepts the presented byte
//   tx_busy               frame in flight or records queued
//   drop_pulse            1-cycle pulse when a record is discarded
//   drop_cnt [15:0]       saturating count of discarded records
// ---------------------------------------------------------------------------
module slr_ins_frame_tx #(
   parameter int          U_DLY      = 1,
   parameter int          DEPTH      = 2,
   parameter logic [15:0] FRAME_HEAD = 16'hEB90,
   parameter logic [7:0]  FRAME_TYPE = 8'h31
) (
   input  logic         clk_sys,
   input  logic         rst_n,
   input  logic [7:0]   cfg_ins_length,
   input  logic [575:0] rxins_data,
   input  logic         rxins_data_valid,
   output logic [7:0]   tx_data,
   output logic         tx_data_valid,
   input  logic         tx_data_ready,
   output logic         tx_busy,
   output logic         drop_pulse,
   output logic [15:0]  drop_cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

`ifdef SLR_INS_FRAME_CRC16_EN
   localparam int          KW       = 16;
   localparam logic [15:0] CHK_INIT = 16'hFFFF;
   localparam logic [5:0]  CHK_LAST = 6'd1;
`else
   localparam int          KW       = 8;
   localparam logic [7:0]  CHK_INIT = 8'h00;
   localparam logic [5:0]  CHK_LAST = 6'd0;
`endif

   // Register updates are zero-delay; U_DLY is accepted for drop-in
   // compatibility only. Unsupported settings open this marker scope.
   if (U_DLY < 0 || DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEAD,
      S_TIME,
      S_DATA,
      S_CHK
   } state_e;

   function automatic logic [KW-1:0] chk_step(input logic [KW-1:0] acc, input logic [7:0] b);
`ifdef SLR_INS_FRAME_CRC16_EN
      logic [15:0] c;
      c = acc ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
      return c;
`else
      return acc + b;
`endif
   endfunction

   // Record storage and queue bookkeeping
   logic [575:0]      mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q, count_d;

   // Frame sequencing
   state_e            state_q, state_d;
   logic [5:0]        idx_q, idx_d;        // byte index within the current phase
   logic [6:0]        len_q, len_d;        // N for the frame in flight, 1..64
   logic [KW-1:0]     chk_q, chk_d;

   // Registered stream outputs
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_valid_q, tx_valid_d;
   logic              drop_q;
   logic [15:0]       drop_cnt_q, drop_cnt_d;

   logic              accept, last_data, frame_done, wr_en, drop;
   logic              frame_start, covered, load;
   logic [7:0]        byte_nx;
   logic [71:0][7:0]  rec_bytes;           // [71] = time MSB, [63] = data byte 0

   assign accept     = tx_valid_q & tx_data_ready;
   assign last_data  = ({1'b0, idx_q} == (len_q - 7'd1));
   assign frame_done = accept & (state_q == S_CHK) & (idx_q == CHK_LAST);
   // The slot freed by the final byte can take a record arriving in the same
   // cycle, so a full buffer only drops when nothing is leaving.
   assign wr_en      = rxins_data_valid & ((count_q != CW'(DEPTH)) | frame_done);
   assign drop       = rxins_data_valid & ~wr_en;
   assign count_d    = count_q + CW'(wr_en) - CW'(frame_done);
   assign rec_bytes  = mem_q[rd_ptr_q];

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               state_d = S_HEAD;
               idx_d   = '0;
            end
         end
         S_HEAD: begin
            if (accept) begin
               if (idx_q == 6'd3) begin
                  state_d = S_TIME;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
         end
         S_TIME: begin
            if (accept) begin
               if (idx_q == 6'd7) begin
                  state_d = S_DATA;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               if (last_data) begin
                  state_d = S_CHK;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
         end
         S_CHK: begin
            if (accept) begin
               if (idx_q == CHK_LAST) begin
                  // count_d includes a record written in this very cycle.
                  state_d = (count_d != '0) ? S_HEAD : S_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output / datapath logic: the byte for (state_d, idx_d) is loaded into
   // the output register whenever the current byte is taken or a frame opens.
   // ------------------------------------------------------------------
   always_comb begin
      frame_start = (state_d == S_HEAD) && (state_q != S_HEAD);
      covered     = accept && (((state_q == S_HEAD) && idx_q[1]) ||
                               (state_q == S_TIME) || (state_q == S_DATA));
      load        = accept || ((state_q == S_IDLE) && (state_d == S_HEAD));

      len_d = len_q;
      chk_d = chk_q;
      if (frame_start) begin
         len_d = ((cfg_ins_length == 8'd0) || (cfg_ins_length > 8'd64)) ? 7'd64
                                                                        : cfg_ins_length[6:0];
         chk_d = CHK_INIT;
      end else if (covered) begin
         chk_d = chk_step(chk_q, tx_data_q);
      end

      byte_nx = 8'h00;
      unique case (state_d)
         S_HEAD: begin
            unique case (idx_d[1:0])
               2'd0:    byte_nx = FRAME_HEAD[15:8];
               2'd1:    byte_nx = FRAME_HEAD[7:0];
               2'd2:    byte_nx = FRAME_TYPE;
               default: byte_nx = 8'd8 + {1'b0, len_q};
            endcase
         end
         S_TIME:  byte_nx = rec_bytes[7'd71 - {4'd0, idx_d[2:0]}];
         S_DATA:  byte_nx = rec_bytes[7'd63 - {1'b0, idx_d}];
`ifdef SLR_INS_FRAME_CRC16_EN
         S_CHK:   byte_nx = idx_d[0] ? chk_d[7:0] : chk_d[15:8];
`else
         S_CHK:   byte_nx = chk_d;
`endif
         default: byte_nx = 8'h00;
      endcase

      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      if (load) begin
         tx_valid_d = (state_d != S_IDLE);
         tx_data_d  = byte_nx;
      end

      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         len_q      <= 7'd64;
         chk_q      <= CHK_INIT;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         drop_q     <= 1'b0;
         drop_cnt_q <= 16'h0000;
      end else begin
         // NOTE: non-blocking assignments make every register see pre-edge values.
         state_q    <= state_d;
         idx_q      <= idx_d;
         len_q      <= len_d;
         chk_q      <= chk_d;
         count_q    <= count_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         drop_q     <= drop;
         drop_cnt_q <= drop_cnt_d;
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (frame_done) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
      end
   end

   // NOTE: payload slots carry no reset; count_q gates every read, so stale contents are never sent.
   always_ff @(posedge clk_sys) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= rxins_data;
      end
   end

   assign tx_data       = tx_data_q;
   assign tx_data_valid = tx_valid_q;
   assign tx_busy       = (state_q != S_IDLE) | (count_q != '0);
   assign drop_pulse    = drop_q;
   assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_slr_ins_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_slr_ins_frame_tx
//
// Bench for slr_ins_frame_tx. Inputs change 1 time unit after the rising
// edge; a monitor on the falling edge compares every output against a
// queue-based frame model and checks handshake stability while stalled.
// Directed sequences cover a single frame, backpressure, overflow,
// simultaneous free/write, length clamping and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_slr_ins_frame_tx;

   localparam int          DEPTH = 2;
   localparam logic [15:0] HEAD  = 16'hEB90;
   localparam logic [7:0]  TYPE  = 8'h31;
`ifdef SLR_INS_FRAME_CRC16_EN
   localparam int TAIL = 2;
`else
   localparam int TAIL = 1;
`endif
   localparam int FL64 = 12 + 64 + TAIL;
   localparam int FL4  = 12 + 4 + TAIL;
   localparam int FL2  = 12 + 2 + TAIL;

   typedef logic [7:0] bq_t[$];

   logic         clk_sys = 1'b0;
   logic         rst_n;
   logic [7:0]   cfg_ins_length;
   logic [575:0] rxins_data;
   logic         rxins_data_valid;
   logic [7:0]   tx_data;
   logic         tx_data_valid;
   logic         tx_data_ready;
   logic         tx_busy;
   logic         drop_pulse;
   logic [15:0]  drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int rdy_mode = 0;   // 0: hold current value, 2: toggle every cycle

   // Model state, owned by the monitor
   logic [575:0] rec_q[$];
   logic [7:0]   exp_q[$];
   logic [7:0]   acc_log[$];
   logic         exp_drop_pulse = 1'b0;
   logic [15:0]  exp_drop_cnt   = 16'h0;
   logic         stall_prev     = 1'b0;
   logic [7:0]   prev_data      = 8'h0;

   logic [575:0] rec1 = {64'h0102030405060708, 32'h11223344, 480'h0};
   logic [7:0]   lit1 [17] = '{8'hEB, 8'h90, 8'h31, 8'h0C,
                               8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                               8'h11, 8'h22, 8'h33, 8'h44, 8'h0B};

   slr_ins_frame_tx #(
      .U_DLY      (1),
      .DEPTH      (DEPTH),
      .FRAME_HEAD (HEAD),
      .FRAME_TYPE (TYPE)
   ) u_dut (
      .clk_sys          (clk_sys),
      .rst_n            (rst_n),
      .cfg_ins_length   (cfg_ins_length),
      .rxins_data       (rxins_data),
      .rxins_data_valid (rxins_data_valid),
      .tx_data          (tx_data),
      .tx_data_valid    (tx_data_valid),
      .tx_data_ready    (tx_data_ready),
      .tx_busy          (tx_busy),
      .drop_pulse       (drop_pulse),
      .drop_cnt         (drop_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame model: built from the field rules, bit-serial CRC.
   function automatic bq_t build_frame(input logic [575:0] rec, input int cfg);
      bq_t         q;
      bq_t         body;
      int          n;
      logic [7:0]  sum;
      logic [15:0] crc;
      logic        fb;
      n = (cfg == 0 || cfg > 64) ? 64 : cfg;
      body.push_back(TYPE);
      body.push_back(8'(8 + n));
      for (int i = 0; i < 8; i++) body.push_back(8'(rec >> (568 - 8 * i)));
      for (int k = 0; k < n; k++) body.push_back(8'(rec >> (504 - 8 * k)));
      sum = 8'h00;
      crc = 16'hFFFF;
      foreach (body[i]) begin
         sum = sum + body[i];
         for (int j = 7; j >= 0; j--) begin
            fb  = crc[15] ^ body[i][j];
            crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         end
      end
      q.push_back(HEAD[15:8]);
      q.push_back(HEAD[7:0]);
      foreach (body[i]) q.push_back(body[i]);
`ifdef SLR_INS_FRAME_CRC16_EN
      q.push_back(crc[15:8]);
      q.push_back(crc[7:0]);
`else
      q.push_back(sum);
`endif
      return q;
   endfunction

   function automatic logic [575:0] make_rec();
      logic [575:0] r;
      for (int w = 0; w < 18; w++) r[w*32 +: 32] = $urandom();
      return r;
   endfunction

   // Monitor: compares outputs with the model, then advances the model with
   // the inputs that the coming rising edge will sample.
   always @(negedge clk_sys) begin
      logic accept;
      logic free_now;
      int   occ;
      if (!rst_n) begin
         check("rst_tx_data", tx_data, 8'h00);
         check("rst_tx_valid", tx_data_valid, 1'b0);
         check("rst_tx_busy", tx_busy, 1'b0);
         check("rst_drop_pulse", drop_pulse, 1'b0);
         check("rst_drop_cnt", drop_cnt, 16'h0);
         rec_q.delete();
         exp_q.delete();
         exp_drop_pulse = 1'b0;
         exp_drop_cnt   = 16'h0;
         stall_prev     = 1'b0;
      end else begin
         occ = rec_q.size() + ((exp_q.size() != 0) ? 1 : 0);
         check("busy", tx_busy, (occ != 0));
         check("drop_pulse", drop_pulse, exp_drop_pulse);
         check("drop_cnt", drop_cnt, exp_drop_cnt);
         if (stall_prev) begin
            check("stall_valid_hold", tx_data_valid, 1'b1);
            check("stall_data_hold", tx_data, prev_data);
         end
         if (tx_data_valid && exp_q.size() == 0) begin
            if (rec_q.size() == 0) begin
               check("spurious_valid", tx_data_valid, 1'b0);
            end else begin
               exp_q = build_frame(rec_q.pop_front(), int'(cfg_ins_length));
            end
         end
         accept   = tx_data_valid && tx_data_ready && (exp_q.size() != 0);
         free_now = accept && (exp_q.size() == 1);
         exp_drop_pulse = 1'b0;
         if (rxins_data_valid) begin
            occ = rec_q.size() + ((exp_q.size() != 0) ? 1 : 0);
            if (occ >= DEPTH && !free_now) begin
               exp_drop_pulse = 1'b1;
               if (exp_drop_cnt != 16'hFFFF) exp_drop_cnt = exp_drop_cnt + 16'd1;
            end else begin
               rec_q.push_back(rxins_data);
            end
         end
         if (accept) begin
            check("tx_byte", tx_data, exp_q[0]);
            void'(exp_q.pop_front());
            acc_log.push_back(tx_data);
         end
         stall_prev = tx_data_valid && !tx_data_ready;
         prev_data  = tx_data;
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
      if (rdy_mode == 2) tx_data_ready = ~tx_data_ready;
   endtask

   task automatic strobe(input logic [575:0] rec);
      rxins_data       = rec;
      rxins_data_valid = 1'b1;
      tick();
      rxins_data_valid = 1'b0;
   endtask

   // Runs until the DUT and the model are both empty; optionally forces a
   // 5-cycle stall once hold_at bytes of the log have been accepted.
   task automatic wait_idle(input string tag, input int hold_at);
      bit done = 1'b0;
      bit held = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         tick();
         if (!held && hold_at >= 0 && acc_log.size() == hold_at) begin
            rdy_mode      = 0;
            tx_data_ready = 1'b0;
            repeat (5) tick();
            rdy_mode = 2;
            held     = 1'b1;
         end
         done = !tx_busy && !tx_data_valid && exp_q.size() == 0 && rec_q.size() == 0;
      end
      check({tag, "_idle_timeout"}, done, 1'b1);
   endtask

   task automatic wait_remaining(input string tag, input int n);
      bit done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         done = tx_data_valid && exp_q.size() == n;
         if (!done) tick();
      end
      check({tag, "_wait_timeout"}, done, 1'b1);
   endtask

   initial begin
      bq_t mq;
      rst_n            = 1'b0;
      cfg_ins_length   = 8'd4;
      rxins_data       = '0;
      rxins_data_valid = 1'b0;
      tx_data_ready    = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Model pins
      mq = build_frame(rec1, 4);
      check("model_len_n4", mq.size(), FL4);
`ifndef SLR_INS_FRAME_CRC16_EN
      foreach (lit1[i]) check($sformatf("model_lit1_%0d", i), mq[i], lit1[i]);
`endif
      mq = build_frame(rec1, 0);
      check("model_len_n0", mq.size(), FL64);
      check("model_lenbyte_n0", mq[3], 8'h48);

      // Single frame, ready held high, latency pinned
      rdy_mode = 0;
      acc_log.delete();
      rxins_data       = rec1;
      rxins_data_valid = 1'b1;
      tick();
      rxins_data_valid = 1'b0;
      check("lat_first_edge_valid", tx_data_valid, 1'b0);
      tick();
      check("lat_second_edge_valid", tx_data_valid, 1'b1);
      check("lat_second_edge_data", tx_data, 8'hEB);
      wait_idle("single", -1);
      check("single_count", acc_log.size(), FL4);
`ifndef SLR_INS_FRAME_CRC16_EN
      foreach (lit1[i]) check($sformatf("single_byte_%0d", i), acc_log[i], lit1[i]);
`endif
      check("single_busy_end", tx_busy, 1'b0);

      // Backpressure: toggling ready plus a 5-cycle stall inside TIME
      acc_log.delete();
      rdy_mode = 2;
      strobe(rec1);
      wait_idle("bp", 6);
      rdy_mode      = 0;
      tx_data_ready = 1'b1;
      check("bp_count", acc_log.size(), FL4);
`ifndef SLR_INS_FRAME_CRC16_EN
      foreach (lit1[i]) check($sformatf("bp_byte_%0d", i), acc_log[i], lit1[i]);
`endif

      // Overflow: three records with the sink stalled
      acc_log.delete();
      tx_data_ready = 1'b0;
      strobe(make_rec());
      strobe(make_rec());
      strobe(make_rec());
      repeat (3) tick();
      check("ovf_drop_cnt", drop_cnt, 16'd1);
      tx_data_ready = 1'b1;
      wait_idle("ovf", -1);
      check("ovf_count", acc_log.size(), 2 * FL4);

      // Simultaneous free and write on a full buffer
      acc_log.delete();
      tx_data_ready = 1'b0;
      strobe(make_rec());
      strobe(make_rec());
      tick();
      tx_data_ready = 1'b1;
      wait_remaining("sim", 1);
      strobe(make_rec());
      wait_idle("sim", -1);
      check("sim_drop_cnt", drop_cnt, 16'd1);
      check("sim_count", acc_log.size(), 3 * FL4);

      // Length clamp and mid-frame length change
      acc_log.delete();
      cfg_ins_length = 8'd0;
      strobe(make_rec());
      wait_idle("clamp0", -1);
      cfg_ins_length = 8'd200;
      strobe(make_rec());
      strobe(make_rec());
      wait_remaining("clamp_mid", 40);
      cfg_ins_length = 8'd2;
      wait_idle("clamp", -1);
      check("clamp_count", acc_log.size(), 2 * FL64 + FL2);
      check("clamp_len0", acc_log[3], 8'h48);
      check("clamp_len200", acc_log[FL64 + 3], 8'h48);
      check("clamp_len2_next", acc_log[2 * FL64 + 3], 8'h0A);

      // Reset during the DATA phase
      cfg_ins_length = 8'd4;
      strobe(make_rec());
      wait_remaining("rst_mid", 4);
      rst_n = 1'b0;
      #1;
      check("rst_now_valid", tx_data_valid, 1'b0);
      check("rst_now_data", tx_data, 8'h00);
      check("rst_now_busy", tx_busy, 1'b0);
      check("rst_now_drop_cnt", drop_cnt, 16'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      acc_log.delete();
      strobe(make_rec());
      wait_idle("post_rst", -1);
      check("post_rst_count", acc_log.size(), FL4);
      check("post_rst_first", acc_log[0], 8'hEB);

      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
